// File: rtl/seq_restoring_divider_pkg.sv
// seq_div_pkg: shared widths, FSM state type and count-width helper for the
// sequential restoring divider.
package seq_div_pkg;

  // Default operand widths: 8-bit dividend/quotient, 4-bit divisor/remainder.
  localparam int DEF_DVD_W = 8;
  localparam int DEF_DVS_W = 4;

  // Width of an iteration counter that has to reach w-1.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

  // Iteration counter width for the default dividend width.
  localparam int DEF_CNT_W = cnt_width(DEF_DVD_W);

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// seq_restoring_divider_if: request/result bundle between the wrapper
// (master) and the divider (slave).
interface seq_restoring_divider_if
  import seq_div_pkg::*;
#(
  parameter int DVD_W = DEF_DVD_W,
  parameter int DVS_W = DEF_DVS_W
);

  logic             start;
  logic [DVD_W-1:0] dividend;
  logic [DVS_W-1:0] divisor;
  logic             busy;
  logic             done;
  logic [DVD_W-1:0] quotient;
  logic [DVS_W-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_restoring_divider_div_step.sv
// div_step: one combinational restoring-division iteration. The trial value
// {R, next dividend bit} is compared against the divisor by a ripple
// subtractor built from fulladd cells; the borrow-free carry out is the
// quotient bit and selects between the difference and the unchanged trial.
module fulladd (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

module div_step
  import seq_div_pkg::*;
#(
  parameter int DVS_W = DEF_DVS_W
) (
  input  logic [DVS_W-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic [DVS_W:0]   rem_o,
  output logic             q_o
);

  logic [DVS_W:0]   trial;
  logic [DVS_W:0]   dvs_inv;
  logic [DVS_W:0]   diff;
  logic [DVS_W+1:0] carry;

  // Trial needs one extra bit: the shifted remainder can reach 2*divisor-1.
  assign trial    = {rem_i, dvd_bit_i};
  assign dvs_inv  = ~{1'b0, divisor_i};
  assign carry[0] = 1'b1;

  // trial - divisor as trial + ~divisor + 1.
  generate
    for (genvar gi = 0; gi <= DVS_W; gi++) begin : g_sub
      fulladd u_fa (
        .a_i (trial[gi]),
        .b_i (dvs_inv[gi]),
        .c_i (carry[gi]),
        .s_o (diff[gi]),
        .c_o (carry[gi+1])
      );
    end
  endgenerate

  // Carry out set means no borrow, i.e. trial >= divisor.
  assign q_o   = carry[DVS_W+1];
  assign rem_o = q_o ? diff : trial;

endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative unsigned restoring divider, one quotient
// bit per clock, MSB first. Divide-by-zero finishes immediately with an
// all-ones quotient. Optional macro SEQ_DIV_EARLY_EXIT_EN finishes
// immediately when dividend < divisor (same results, shorter latency).
module seq_restoring_divider
  import seq_div_pkg::*;
#(
  parameter int DVD_W = DEF_DVD_W,
  parameter int DVS_W = DEF_DVS_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_restoring_divider_if.slave  bus
);

  localparam int CNT_W = cnt_width(DVD_W);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [DVS_W:0]   rem_q;        // working partial remainder
  logic [DVD_W-1:0] dvd_q;        // dividend shifting out, quotient shifting in
  logic [DVS_W-1:0] dvs_q;        // latched divisor

  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [DVD_W-1:0] quotient_q;
  logic [DVS_W-1:0] remainder_q;

  logic [DVS_W:0]   rem_d;
  logic             qbit_d;
  logic             early_exit;
  logic             unused_rem_msb;

  // The partial remainder stays below the divisor, so its top bit is
  // always zero; it is kept only so the register matches the trial width.
  assign unused_rem_msb = rem_q[DVS_W];

`ifdef SEQ_DIV_EARLY_EXIT_EN
  assign early_exit = (bus.dividend < DVD_W'(bus.divisor));
`else
  assign early_exit = 1'b0;
`endif

  div_step #(
    .DVS_W (DVS_W)
  ) u_step (
    .rem_i     (rem_q[DVS_W-1:0]),
    .dvd_bit_i (dvd_q[DVD_W-1]),
    .divisor_i (dvs_q),
    .rem_o     (rem_d),
    .q_o       (qbit_d)
  );

  // Control FSM with the iteration datapath and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            dvd_q   <= bus.dividend;
            dvs_q   <= bus.divisor;
            rem_q   <= '0;
            count_q <= CNT_W'(DVD_W - 1);
            dbz_q   <= 1'b0;
            if (bus.divisor == '0) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              dbz_q       <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= '0;
            end else if (early_exit) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              quotient_q  <= '0;
              remainder_q <= bus.dividend[DVS_W-1:0];
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          rem_q   <= rem_d;
          dvd_q   <= {dvd_q[DVD_W-2:0], qbit_d};
          count_q <= count_q - 1'b1;
          if (count_q == '0) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= {dvd_q[DVD_W-2:0], qbit_d};
            remainder_q <= rem_d[DVS_W-1:0];
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule
